fact_job_sequencer: RTL

//  Bus-master controller that runs a batch of factorial jobs on the factorial core with no CPU involvement.
//  Per job:
//   - read an operand from memory;
//   - program the core (operand, intrEn, opstart) and wait for its interrupt;
//   - read result_h/result_l and write both words back to memory;
//   - clear the core.

---
 rtl/fact_job_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fact_job_sequencer.sv
// Bus-master sequencer that walks a table of operands through the factorial core
// and writes each 128-bit result back to memory as a high/low word pair.
module fact_job_sequencer #(
  parameter logic [15:0] FACT_BASE = 16'h7000,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src_base,
  input  logic [15:0] dst_base,
  input  logic [7:0]  count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        m_req,
  input  logic        m_grant,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din,
  input  logic        f_interrupt
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [15:0] REG_OPSTART  = FACT_BASE + 16'h0000;
  localparam logic [15:0] REG_OPCLEAR  = FACT_BASE + 16'h0008;
  localparam logic [15:0] REG_INTREN   = FACT_BASE + 16'h0018;
  localparam logic [15:0] REG_OPERAND  = FACT_BASE + 16'h0020;
  localparam logic [15:0] REG_RESULT_H = FACT_BASE + 16'h0028;
  localparam logic [15:0] REG_RESULT_L = FACT_BASE + 16'h0030;

  typedef enum logic [4:0] {
    S_IDLE,
    S_GRANT,
    S_OP_RA,
    S_OP_RD,
    S_W_OPND,
    S_W_INTEN,
    S_W_START,
    S_WAIT_INT,
    S_RH_RA,
    S_RH_RD,
    S_RL_RA,
    S_RL_RD,
    S_W_RES_H,
    S_W_RES_L,
    S_W_CLR1,
    S_W_CLR0,
    S_NEXT,
    S_DONE,
    S_E_CLR1,
    S_E_CLR0
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   src_q, src_d;
  logic [15:0]   dst_q, dst_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [63:0]   opnd_q, opnd_d;
  logic [63:0]   res_h_q, res_h_d;
  logic [63:0]   res_l_q, res_l_d;
  logic          error_q, error_d;

  logic [15:0] job_src;
  logic [15:0] job_dst;
  logic        last_job;
  logic        bus_ok;

  assign job_src  = src_q + {8'd0, idx_q};
  assign job_dst  = dst_q + {7'd0, idx_q, 1'b0};
  assign last_job = (({1'b0, idx_q} + 9'd1) == {1'b0, cnt_q});
  assign bus_ok   = m_req & m_grant;

  // Bus outputs are a pure decode of the current state and latched data, so they
  // stay stable for as long as the arbiter withholds the grant.
  always_comb begin
    m_req  = 1'b1;
    m_wr   = 1'b0;
    m_addr = 16'd0;
    m_dout = 64'd0;
    case (state_q)
      S_IDLE, S_DONE: m_req = 1'b0;
      S_OP_RA, S_OP_RD: m_addr = job_src;
      S_W_OPND: begin
        m_wr   = 1'b1;
        m_addr = REG_OPERAND;
        m_dout = opnd_q;
      end
      S_W_INTEN: begin
        m_wr   = 1'b1;
        m_addr = REG_INTREN;
        m_dout = 64'd1;
      end
      S_W_START: begin
        m_wr   = 1'b1;
        m_addr = REG_OPSTART;
        m_dout = 64'd1;
      end
      S_RH_RA, S_RH_RD: m_addr = REG_RESULT_H;
      S_RL_RA, S_RL_RD: m_addr = REG_RESULT_L;
      S_W_RES_H: begin
        m_wr   = 1'b1;
        m_addr = job_dst;
        m_dout = res_h_q;
      end
      S_W_RES_L: begin
        m_wr   = 1'b1;
        m_addr = job_dst + 16'd1;
        m_dout = res_l_q;
      end
      S_W_CLR1, S_E_CLR1: begin
        m_wr   = 1'b1;
        m_addr = REG_OPCLEAR;
        m_dout = 64'd1;
      end
      S_W_CLR0, S_E_CLR0: begin
        m_wr   = 1'b1;
        m_addr = REG_OPCLEAR;
        m_dout = 64'd0;
      end
      default: ;
    endcase
  end

  // An empty batch reaches DONE with cnt_q == 0 and reports busy for that cycle.
  assign busy  = (state_q != S_IDLE) && !((state_q == S_DONE) && (cnt_q != 8'd0));
  assign done  = (state_q == S_DONE);
  assign error = error_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    opnd_d  = opnd_q;
    res_h_d = res_h_q;
    res_l_d = res_l_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          cnt_d   = count;
          idx_d   = 8'd0;
          error_d = 1'b0;
          state_d = (count == 8'd0) ? S_DONE : S_GRANT;
        end
      end
      S_GRANT:   if (bus_ok) state_d = S_OP_RA;
      S_OP_RA:   if (bus_ok) state_d = S_OP_RD;
      S_OP_RD: begin
        if (bus_ok) begin
          opnd_d  = m_din;
          state_d = S_W_OPND;
        end
      end
      S_W_OPND:  if (bus_ok) state_d = S_W_INTEN;
      S_W_INTEN: if (bus_ok) state_d = S_W_START;
      S_W_START: begin
        if (bus_ok) begin
          tmo_d   = '0;
          state_d = S_WAIT_INT;
        end
      end
      S_WAIT_INT: begin
        if (f_interrupt) begin
          state_d = S_RH_RA;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_E_CLR1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RH_RA:   if (bus_ok) state_d = S_RH_RD;
      S_RH_RD: begin
        if (bus_ok) begin
          res_h_d = m_din;
          state_d = S_RL_RA;
        end
      end
      S_RL_RA:   if (bus_ok) state_d = S_RL_RD;
      S_RL_RD: begin
        if (bus_ok) begin
          res_l_d = m_din;
          state_d = S_W_RES_H;
        end
      end
      S_W_RES_H: if (bus_ok) state_d = S_W_RES_L;
      S_W_RES_L: if (bus_ok) state_d = S_W_CLR1;
      S_W_CLR1:  if (bus_ok) state_d = S_W_CLR0;
      S_W_CLR0:  if (bus_ok) state_d = S_NEXT;
      S_NEXT: begin
        if (last_job) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_OP_RA;
        end
      end
      S_DONE:    state_d = S_IDLE;
      S_E_CLR1:  if (bus_ok) state_d = S_E_CLR0;
      S_E_CLR0: begin
        if (bus_ok) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= 16'd0;
      dst_q   <= 16'd0;
      cnt_q   <= 8'd0;
      idx_q   <= 8'd0;
      tmo_q   <= '0;
      opnd_q  <= 64'd0;
      res_h_q <= 64'd0;
      res_l_q <= 64'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      opnd_q  <= opnd_d;
      res_h_q <= res_h_d;
      res_l_q <= res_l_d;
      error_q <= error_d;
    end
  end

endmodule
